// File: rtl/queue_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : queue_write_arbiter_pkg
//  Description : Shared types and helpers for the queue write-port arbiter.
//                - arb_state_e : arbiter state (idle / packet locked)
//                - clog2_min1  : index width for a requester count, never 0
//  Revision    : 1.0 - initial release
// ============================================================================
package queue_write_arbiter_pkg;

  // Arbiter state. IDLE arbitrates every cycle; LOCKED keeps the grant on
  // one requester until the last beat of its packet has been accepted.
  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Width needed to hold an index in [0, n-1]. A single requester still
  // gets a 1-bit index so that no port or register collapses to zero width.
  function automatic int clog2_min1(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage : queue_write_arbiter_pkg
`default_nettype wire

// File: rtl/queue_write_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_priority_select
//  Description : Combinational round-robin picker. Returns the first asserted
//                request found when scanning prio, prio+1, ... wrapping at
//                NREQ (which need not be a power of two).
//
//  Ports
//    req  [NREQ]   in   request vector
//    prio [IBITS]  in   index with the highest priority this cycle
//    sel  [IBITS]  out  chosen index (equals prio when no request is set)
//    any           out  at least one request is set
//
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_select
  import queue_write_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int IBITS = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IBITS-1:0] prio,
  output logic [IBITS-1:0] sel,
  output logic             any
);

  // One extra bit so prio + offset can be compared against NREQ without
  // overflowing before the modulo correction.
  localparam logic [IBITS:0] NREQ_W = (IBITS + 1)'(NREQ);

  logic [IBITS-1:0]  w_prio_eff;
  logic [2*NREQ-1:0] w_req_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IBITS-1:0]  w_off;
  logic [IBITS:0]    w_sum;

  always_comb begin
    // An out-of-range priority cannot be produced by the arbiter; clamping it
    // keeps the rotation well defined for non power-of-two NREQ regardless.
    w_prio_eff = ({1'b0, prio} < NREQ_W) ? prio : '0;

    // Rotate: concatenating the vector with itself and shifting right by prio
    // puts requester prio at bit 0 and wraps the lower indices above it.
    w_req_dbl = {req, req};
    w_rot     = NREQ'(w_req_dbl >> w_prio_eff);

    // Find-first from bit 0 upward (descending loop, last write wins).
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IBITS'(i);
      end
    end

    // Unrotate: add the offset back onto prio modulo NREQ.
    w_sum = {1'b0, w_prio_eff} + {1'b0, w_off};
    if (w_sum >= NREQ_W) begin
      w_sum = w_sum - NREQ_W;
    end

    sel = w_sum[IBITS-1:0];
    any = |req;
  end

endmodule : rr_priority_select
`default_nettype wire

// File: rtl/queue_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : queue_write_arbiter
//  Description : Round-robin arbiter sharing the write port of one clock-
//                crossing queue between NREQ val/rdy requesters. Multi-beat
//                packets hold the grant until their last beat is accepted, so
//                packets never interleave. Each beat is tagged with the index
//                of its source. Zero latency, no message storage.
//
//  Ports
//    clk                in   write-side clock of the queue
//    reset              in   synchronous, active-high
//    in_val  [NREQ]     in   per-requester valid
//    in_rdy  [NREQ]     out  per-requester ready (one-hot or zero)
//    in_msg  [NREQ*NBITS] in requester i occupies [i*NBITS +: NBITS]
//    in_last [NREQ]     in   beat is the final one of its packet
//    out_val            out  to queue write valid
//    out_rdy            in   from queue write ready
//    out_msg [NBITS]    out  to queue write data
//    out_src [IBITS]    out  index of the requester driving out_msg
//    locked             out  a multi-beat packet is in progress
//
//  Revision    : 1.0 - initial release
// ============================================================================
module queue_write_arbiter
  import queue_write_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NBITS = 32,
  localparam int IBITS = clog2_min1(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       in_val,
  output logic [NREQ-1:0]       in_rdy,
  input  logic [NREQ*NBITS-1:0] in_msg,
  input  logic [NREQ-1:0]       in_last,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [NBITS-1:0]      out_msg,
  output logic [IBITS-1:0]      out_src,
  output logic                  locked
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e       state_q, state_d;
  logic [IBITS-1:0] grant_q, grant_d;   // holder of the lock
  logic [IBITS-1:0] prio_q,  prio_d;    // first index scanned when idle

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [IBITS-1:0] w_pick_sel;
  logic             w_pick_any;
  logic [IBITS-1:0] w_sel;
  logic             w_sel_val;
  logic             w_sel_last;
  logic             w_offer;
  logic             w_fire;

  rr_priority_select #(
    .NREQ (NREQ)
  ) u_pick (
    .req  (in_val),
    .prio (prio_q),
    .sel  (w_pick_sel),
    .any  (w_pick_any)
  );

  // Next index after idx, wrapping at NREQ rather than at 2**IBITS.
  function automatic logic [IBITS-1:0] wrap_inc(input logic [IBITS-1:0] idx);
    if (idx == IBITS'(NREQ - 1)) begin
      return '0;
    end
    return idx + IBITS'(1);
  endfunction

  always_comb begin
    // While locked the holder owns the port even if it is momentarily idle;
    // otherwise the round-robin pick decides this cycle.
    w_sel = (state_q == ARB_LOCKED) ? grant_q : w_pick_sel;

    w_sel_val  = 1'b0;
    w_sel_last = 1'b0;
    out_msg    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == IBITS'(i)) begin
        w_sel_val  = in_val[i];
        w_sel_last = in_last[i];
        out_msg    = in_msg[i*NBITS +: NBITS];
      end
    end

    // w_offer: the port is being offered to w_sel. When locked this is
    // independent of the holder's in_val, so a requester that computes its
    // valid from its ready cannot close a loop through the arbiter.
    w_offer = !reset && ((state_q == ARB_LOCKED) || w_pick_any);

    if (reset) begin
      out_val = 1'b0;
    end else if (state_q == ARB_LOCKED) begin
      out_val = w_sel_val;
    end else begin
      out_val = w_pick_any;
    end

    in_rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      in_rdy[i] = w_offer && out_rdy && (w_sel == IBITS'(i));
    end

    out_src = w_sel;
    locked  = !reset && (state_q == ARB_LOCKED);
    w_fire  = out_val && out_rdy;
  end

  // --------------------------------------------------------------------------
  // Next-state logic: only an accepted beat can move the arbiter. Stalls from
  // the queue and bubbles from the lock holder leave everything untouched.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;

    if (w_fire) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (w_sel_last) begin
            // Single-beat packet: stay idle, rotate past the winner.
            prio_d = wrap_inc(w_sel);
          end else begin
            state_d = ARB_LOCKED;
            grant_d = w_sel;
          end
        end
        ARB_LOCKED: begin
          if (w_sel_last) begin
            state_d = ARB_IDLE;
            prio_d  = wrap_inc(grant_q);
          end
        end
        default: begin
          state_d = ARB_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  // --------------------------------------------------------------------------
  // Structural properties
  // --------------------------------------------------------------------------
  a_rdy_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(in_rdy));

  a_index_range : assert property (@(posedge clk) disable iff (reset)
    (int'(grant_q) < NREQ) && (int'(prio_q) < NREQ));

  a_rdy_needs_out_rdy : assert property (@(posedge clk) disable iff (reset)
    (in_rdy != '0) |-> out_rdy);

endmodule : queue_write_arbiter
`default_nettype wire
